// File: rtl/bus_arb.sv
// Four-way bus arbiter with rotating priority, reply timeout alarm
// and a forced idle gap between consecutive grants.
module bus_arb #(
   parameter int ALARM_TICKS = 250,
   parameter int GAP_CYCLES  = 2
) (
   input  logic       __clk,
   input  logic       clo,
   input  logic [3:0] zg,
   input  logic [3:0] zz,
   input  logic       rok,
   input  logic       ren,
   input  logic       rpe,
   output logic [3:0] zw,
   output logic [1:0] owner,
   output logic       busy,
   output logic       talarm,
   output logic       replied
);

   typedef enum logic [1:0] {IDLE, GRANT, HOLD, GAP} state_t;

   localparam logic [15:0] TMO   = 16'(ALARM_TICKS - 1);
   localparam logic [3:0]  GAP_N = 4'(GAP_CYCLES);

   state_t      state, state_n;
   logic [3:0]  zw_n;
   logic [1:0]  owner_n;
   logic [1:0]  last, last_n;
   logic [15:0] timer, timer_n;
   logic        talarm_n;
   logic        replied_n;
   logic        busy_n;
   logic [3:0]  gap_cnt, gap_n;

   logic [3:0]  er;
   logic        alive;
   logic        reply;
   logic        found;
   logic [1:0]  sel;
   logic [1:0]  idx;

   assign er    = zg & zz;
   assign alive = er[owner];
   assign reply = rok | ren | rpe;

   // Search starts just after the last grantee so it gets lowest priority.
   always_comb begin
      found = 1'b0;
      sel   = 2'd0;
      idx   = 2'd0;
      for (int k = 1; k <= 4; k++) begin
         idx = last + 2'(k);
         if (!found && er[idx]) begin
            found = 1'b1;
            sel   = idx;
         end
      end
   end

   always_comb begin
      state_n   = state;
      zw_n      = zw;
      owner_n   = owner;
      last_n    = last;
      timer_n   = timer;
      talarm_n  = 1'b0;
      replied_n = replied;
      gap_n     = gap_cnt;
      unique case (state)
         IDLE, GAP: begin
            if (state == GAP && gap_cnt > 4'd1) begin
               gap_n = gap_cnt - 4'd1;
            end else if (found) begin
               state_n   = GRANT;
               zw_n      = 4'b0001 << sel;
               owner_n   = sel;
               timer_n   = 16'd0;
               replied_n = 1'b0;
            end else begin
               state_n = IDLE;
            end
         end
         GRANT: begin
            if (timer != 16'hFFFF)
               timer_n = timer + 16'd1;
            if (reply) begin
               replied_n = 1'b1;
               state_n   = HOLD;
            end else if (!alive) begin
               zw_n      = 4'b0000;
               replied_n = 1'b0;
               last_n    = owner;
               gap_n     = GAP_N;
               state_n   = GAP;
            end else if (timer == TMO) begin
               talarm_n = 1'b1;
               state_n  = HOLD;
            end
         end
         HOLD: begin
            if (!alive) begin
               zw_n      = 4'b0000;
               replied_n = 1'b0;
               last_n    = owner;
               gap_n     = GAP_N;
               state_n   = GAP;
            end
         end
      endcase
      busy_n = |zw_n;
   end

   always_ff @(posedge __clk) begin
      if (clo) begin
         state   <= IDLE;
         zw      <= 4'b0000;
         owner   <= 2'd0;
         last    <= 2'd3;
         timer   <= 16'd0;
         talarm  <= 1'b0;
         replied <= 1'b0;
         busy    <= 1'b0;
         gap_cnt <= 4'd0;
      end else begin
         state   <= state_n;
         zw      <= zw_n;
         owner   <= owner_n;
         last    <= last_n;
         timer   <= timer_n;
         talarm  <= talarm_n;
         replied <= replied_n;
         busy    <= busy_n;
         gap_cnt <= gap_n;
      end
   end

endmodule

// File: tb/tb_bus_arb.sv
// Bench for bus_arb: directed scenarios then randomized traffic,
// all outputs compared each cycle against a transaction-level model.
module tb_bus_arb;

   localparam int ALARM = 250;
   localparam int GAPC  = 2;

   logic       clk;
   logic       clo;
   logic [3:0] zg;
   logic [3:0] zz;
   logic       rok;
   logic       ren;
   logic       rpe;
   logic [3:0] zw;
   logic [1:0] owner;
   logic       busy;
   logic       talarm;
   logic       replied;

   int n_checks = 0;
   int n_errors = 0;

   // Model: who holds the bus (-1 none), how long, and whether the
   // grant has already been settled by a reply or a timeout.
   int m_gnt  = -1;
   int m_own  = 0;
   int m_last = 3;
   int m_age  = 0;
   int m_gap  = 0;
   bit m_done = 0;
   bit m_rep  = 0;
   bit m_alm  = 0;

   bus_arb #(.ALARM_TICKS(ALARM), .GAP_CYCLES(GAPC)) dut (
      .__clk  (clk),
      .clo    (clo),
      .zg     (zg),
      .zz     (zz),
      .rok    (rok),
      .ren    (ren),
      .rpe    (rpe),
      .zw     (zw),
      .owner  (owner),
      .busy   (busy),
      .talarm (talarm),
      .replied(replied)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_checks++;
      assert (got === exp) else begin
         n_errors++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic void release_bus();
      m_last = m_own;
      m_gnt  = -1;
      m_rep  = 0;
      m_gap  = GAPC;
   endfunction

   function automatic void model_edge();
      logic [3:0] er;
      int i;
      er    = zg & zz;
      m_alm = 0;
      if (clo) begin
         m_gnt  = -1;
         m_own  = 0;
         m_last = 3;
         m_gap  = 0;
         m_rep  = 0;
      end else if (m_gnt < 0) begin
         if (m_gap > 1) begin
            m_gap--;
         end else begin
            m_gap = 0;
            for (int k = 1; k <= 4; k++) begin
               i = (m_last + k) % 4;
               if (m_gnt < 0 && er[i]) begin
                  m_gnt  = i;
                  m_own  = i;
                  m_age  = 0;
                  m_done = 0;
               end
            end
         end
      end else if (!m_done) begin
         if (rok || ren || rpe) begin
            m_rep  = 1;
            m_done = 1;
         end else if (!er[m_gnt]) begin
            release_bus();
         end else if (m_age == ALARM - 1) begin
            m_alm  = 1;
            m_done = 1;
         end
         m_age++;
      end else if (!er[m_gnt]) begin
         release_bus();
      end
   endfunction

   task automatic step();
      logic [3:0] ezw;
      @(posedge clk);
      model_edge();
      #1;
      ezw = (m_gnt < 0) ? 4'b0000 : 4'(1 << m_gnt);
      check("zw", 32'(zw), 32'(ezw));
      check("owner", 32'(owner), 32'(m_own));
      check("busy", 32'(busy), 32'(m_gnt >= 0));
      check("talarm", 32'(talarm), 32'(m_alm));
      check("replied", 32'(replied), 32'(m_rep));
   endtask

   task automatic do_reset();
      clo = 1'b1;
      zg  = 4'b0000;
      rok = 1'b0;
      ren = 1'b0;
      rpe = 1'b0;
      step();
      step();
      clo = 1'b0;
   endtask

   int cnt;
   int zeros;
   bit seen_alarm;
   int order [5] = '{0, 1, 2, 3, 0};

   initial begin
      clo = 1'b1;
      zg  = 4'b0000;
      zz  = 4'b1111;
      rok = 1'b0;
      ren = 1'b0;
      rpe = 1'b0;

      // Reset state
      do_reset();
      check("rst_zw", 32'(zw), 32'h0);
      check("rst_owner", 32'(owner), 32'h0);

      // Single request, reply, release, gap
      zg = 4'b0001;
      step();
      check("s1_zw", 32'(zw), 32'h1);
      check("s1_busy", 32'(busy), 32'h1);
      rok = 1'b1;
      step();
      rok = 1'b0;
      check("s1_replied", 32'(replied), 32'h1);
      zg = 4'b0000;
      step();
      check("s1_rel", 32'(zw), 32'h0);
      step();
      step();
      step();

      // Round robin with all requesting
      do_reset();
      zg  = 4'b1111;
      cnt = 0;
      while (zw == 4'b0000 && cnt < 20) begin
         step();
         cnt++;
      end
      check("rr_first", 32'(cnt), 32'd1);
      for (int g = 0; g < 5; g++) begin
         check("rr_order", 32'(owner), 32'(order[g]));
         rok = 1'b1;
         step();
         rok = 1'b0;
         zg[owner] = 1'b0;
         step();
         zg = 4'b1111;
         zeros = 0;
         while (zw == 4'b0000 && zeros < 20) begin
            zeros++;
            step();
         end
         check("rr_gap", 32'(zeros), 32'(GAPC));
      end

      // Timeout with no reply
      do_reset();
      zg = 4'b0010;
      step();
      check("to_zw", 32'(zw), 32'h2);
      cnt = 0;
      while (!talarm && cnt < 400) begin
         step();
         cnt++;
      end
      check("to_cycle", 32'(cnt), 32'(ALARM));
      check("to_replied", 32'(replied), 32'h0);
      step();
      check("to_pulse", 32'(talarm), 32'h0);
      repeat (5) step();
      check("to_hold", 32'(zw), 32'h2);
      zg = 4'b0000;
      step();
      check("to_rel", 32'(zw), 32'h0);

      // Reply on the timeout cycle wins
      do_reset();
      zg = 4'b0100;
      step();
      seen_alarm = 0;
      repeat (ALARM - 1) begin
         step();
         seen_alarm |= talarm;
      end
      rok = 1'b1;
      step();
      rok = 1'b0;
      seen_alarm |= talarm;
      check("tie_replied", 32'(replied), 32'h1);
      repeat (3) begin
         step();
         seen_alarm |= talarm;
      end
      check("tie_noalarm", 32'(seen_alarm), 32'h0);

      // Reset in the middle of a grant
      zg = 4'b0000;
      do_reset();
      zg = 4'b0100;
      repeat (3) step();
      check("mr_zw", 32'(zw), 32'h4);
      clo = 1'b1;
      step();
      check("mr_drop", 32'(zw), 32'h0);
      check("mr_owner", 32'(owner), 32'h0);
      clo = 1'b0;
      zg  = 4'b0101;
      step();
      check("mr_first", 32'(zw), 32'h1);

      // Masked module is never granted
      zg = 4'b0000;
      do_reset();
      zz = 4'b1011;
      zg = 4'b0100;
      repeat (10) step();
      check("mask_zw", 32'(zw), 32'h0);
      zz = 4'b1111;
      step();
      check("mask_go", 32'(zw), 32'h4);

      // Randomized traffic
      zg = 4'b0000;
      do_reset();
      for (int c = 0; c < 4000; c++) begin
         if ($urandom_range(7) == 0)
            zg = 4'($urandom);
         if ($urandom_range(15) == 0)
            zz = ($urandom_range(3) == 0) ? 4'($urandom) : 4'hF;
         rok = ($urandom_range(24) == 0);
         ren = ($urandom_range(49) == 0);
         rpe = ($urandom_range(49) == 0);
         clo = ($urandom_range(599) == 0);
         step();
      end
      clo = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors",
               n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/bus_arb.md
BUS_ARB -- requirements
Module: bus_arb

Interface
REQ-001 SHALL have parameter ALARM_TICKS, default 250, meaning grant-to-reply timeout in clock cycles (5 us at 50 MHz); legal range 2..65535.
REQ-002 SHALL have parameter GAP_CYCLES, default 2, meaning bus-idle cycles forced between grants; legal range 1..15.
REQ-003 SHALL have port __clk  input  1  system clock; all state changes on its rising edge.
REQ-004 SHALL have port clo  input  1  general clear; reset is synchronous and active-high.
REQ-005 SHALL have port zg  input  4  bus request (ZGłoszenie) from modules 0..3; bit i = module i.
REQ-006 SHALL have port zz  input  4  module-present mask; zz[i]=0 masks zg[i].
REQ-007 SHALL have port rok  input  1  responder OK reply.
REQ-008 SHALL have port ren  input  1  responder EN (no-such-address) reply.
REQ-009 SHALL have port rpe  input  1  responder parity-error reply.
REQ-010 SHALL have port zw  output  4  bus grant (ZezWolenie), one-hot or zero.
REQ-011 SHALL have port owner  output  2  index of current/last grantee.
REQ-012 SHALL have port busy  output  1  high while any zw bit high.
REQ-013 SHALL have port talarm  output  1  one-cycle timeout-alarm pulse to current grantee.
REQ-014 SHALL have port replied  output  1  high from first reply in a grant until grant ends.

Function
REQ-015 SHALL implement registered states IDLE, GRANT, HOLD, GAP; all outputs registered.
REQ-016 SHALL define effective request er = zg & zz; unmasked bits never granted.
REQ-017 IDLE: if er != 0, SHALL select first set bit searching (last+1) mod 4 upward with wrap; next edge zw = onehot(sel), owner = sel, timer = 0, state GRANT; er = 0 stays IDLE, zw = 0.
REQ-018 Grant latency SHALL be exactly 1 cycle: er sampled at edge n in IDLE -> zw high after edge n.
REQ-019 GRANT: timer SHALL increment by 1 per cycle, saturating; no wrap.
REQ-020 GRANT: any of rok|ren|rpe high -> replied = 1, state HOLD, zw unchanged.
REQ-021 GRANT: no reply and timer == ALARM_TICKS-1 -> talarm = 1 for exactly one cycle, state HOLD, replied stays 0.
REQ-022 Reply and timeout in same cycle SHALL resolve as reply; talarm stays 0.
REQ-023 GRANT: zg[owner] low with no reply same cycle -> abort: zw = 0, last = owner, state GAP; reply same cycle takes precedence (HOLD).
REQ-024 HOLD: zw held while zg[owner] high; zg[owner] low -> zw = 0, replied = 0, last = owner, state GAP.
REQ-025 HOLD: further replies SHALL be ignored; no second talarm.
REQ-026 GAP: zw = 0 for exactly GAP_CYCLES cycles, then IDLE; requests arriving in GAP held off, not lost (level-sensitive).
REQ-027 Replies outside GRANT SHALL be ignored.
REQ-028 zz[owner] dropping during GRANT/HOLD SHALL be treated as zg[owner] low.
REQ-029 At most one zw bit SHALL be high in any cycle; busy = |zw.

Reset
REQ-030 clo high at edge SHALL force state IDLE, zw = 0, busy = 0, talarm = 0, replied = 0, timer = 0, owner = 0, last = 3 (module 0 first priority), regardless of state.
REQ-031 Reset mid-GRANT/HOLD SHALL drop zw on that edge with no talarm and no GAP.
REQ-032 First grant after clo low SHALL follow REQ-017 from IDLE, earliest one edge after clo deasserts.

Verification
REQ-033 Reset, zz=1111, zg=0001 -> after 1 edge zw=0001, owner=0, busy=1; rok pulse -> replied=1; zg=0000 -> zw=0000, then 2 idle cycles.
REQ-034 zg=1111 held, each grantee drops zg 1 cycle after rok -> grant order 0,1,2,3,0, GAP_CYCLES zero-zw cycles between each.
REQ-035 zg=0010, no reply -> talarm=1 only on 250th cycle after zw=0010, replied=0, zw held until zg[1]=0.
REQ-036 zg=0100, rok on cycle matching timeout -> replied=1, talarm never 1.
REQ-037 Grant to module 2 then clo=1 mid-GRANT -> next edge zw=0000, owner=0; clo=0 with zg=0101 -> zw=0001.
REQ-038 zz=1011, zg=0100 -> zw stays 0000 indefinitely; set zz=1111 -> zw=0100 one cycle later.
